// File: rtl/conv_window_fetch.sv
// Window read sequencer: walks a KSIZE x KSIZE window over a row-major feature map,
// drives one buffer read port per window slot and presents each captured window on valid/ready.
module conv_window_lane #(
  parameter int unsigned            WIDTH      = 16,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            IMG_W      = 28,
  parameter int unsigned            STRIDE     = 1,
  parameter int unsigned            KI         = 0,
  parameter int unsigned            KJ         = 0,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           r,
  input  logic [15:0]           c,
  input  logic                  cap,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      win_word
);
  logic [ADDR_WIDTH-1:0] row, col;

  // Map coordinates of this slot; all arithmetic stays at address width.
  assign row     = ADDR_WIDTH'(r) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(KI);
  assign col     = ADDR_WIDTH'(c) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(KJ);
  assign rd_addr = BASE_ADDR + row * ADDR_WIDTH'(IMG_W) + col;

  always_ff @(posedge clk) begin
    if (!rst_n)   win_word <= '0;
    else if (cap) win_word <= rd_data;
  end
endmodule

module conv_window_fetch #(
  parameter int unsigned            WIDTH      = 16,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            KSIZE      = 5,
  parameter int unsigned            PORT_NUM   = 25,
  parameter int unsigned            IMG_W      = 28,
  parameter int unsigned            IMG_H      = 28,
  parameter int unsigned            STRIDE     = 1,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
  input  logic [PORT_NUM*WIDTH-1:0]      rd_data_NP,
  output logic [PORT_NUM*WIDTH-1:0]      win_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [15:0]                    win_row,
  output logic [15:0]                    win_col,
  output logic                           win_last
);
  localparam int unsigned OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
  localparam int unsigned OUT_H = (IMG_H - KSIZE) / STRIDE + 1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t                               state;
  logic [15:0]                          r, c;
  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]  addr;
  logic [PORT_NUM-1:0][WIDTH-1:0]       rdat, wdat;
  logic                                 cap, at_end, col_end;

  assign rdat       = rd_data_NP;
  assign rd_addr_NP = addr;
  assign win_data   = wdat;
  assign cap        = (state == FETCH);
  assign col_end    = (c == 16'(OUT_W - 1));
  assign at_end     = (r == 16'(OUT_H - 1)) && col_end;

  for (genvar k = 0; k < PORT_NUM; k++) begin : g_lane
    conv_window_lane #(
      .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .IMG_W(IMG_W), .STRIDE(STRIDE),
      .KI(k / KSIZE), .KJ(k % KSIZE), .BASE_ADDR(BASE_ADDR)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .r(r), .c(c), .cap(cap),
      .rd_data(rdat[k]), .rd_addr(addr[k]), .win_word(wdat[k])
    );
  end

  // win_valid is always high in PRESENT, so win_ready alone completes the handshake there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          r     <= '0;
          c     <= '0;
          busy  <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          win_row   <= r;
          win_col   <= c;
          win_last  <= at_end;
          win_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: if (win_ready) begin
          win_valid <= 1'b0;
          if (win_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (col_end) begin
              c <= '0;
              r <= r + 16'd1;
            end else begin
              c <= c + 16'd1;
            end
            state <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: default 28x28/K5 instance plus a K3/stride-2/base-100 instance,
// both reading a shared behavioural buffer and checked against a window-order reference model.
module tb_conv_window_fetch;
  logic clk, rst_n;
  logic st1, st2, rdy1, rdy2;
  logic b1, b2, d1, d2, v1, v2, l1, l2;
  logic [15:0]  r1, r2, c1, c2;
  logic [799:0] a1;
  logic [287:0] a2;
  logic [399:0] rd1, w1;
  logic [143:0] rd2, w2;
  logic [15:0]  mem [1024];
  int vectors = 0, miscompares = 0;

  conv_window_fetch dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .busy(b1), .done(d1),
    .rd_addr_NP(a1), .rd_data_NP(rd1), .win_data(w1), .win_valid(v1),
    .win_ready(rdy1), .win_row(r1), .win_col(c1), .win_last(l1));

  conv_window_fetch #(.KSIZE(3), .PORT_NUM(9), .IMG_W(8), .IMG_H(8), .STRIDE(2),
                      .BASE_ADDR(32'd100)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .busy(b2), .done(d2),
    .rd_addr_NP(a2), .rd_data_NP(rd2), .win_data(w2), .win_valid(v2),
    .win_ready(rdy2), .win_row(r2), .win_col(c2), .win_last(l2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational buffer read ports.
  always_comb begin
    rd1 = '0;
    for (int k = 0; k < 25; k++) rd1[k*16 +: 16] = mem[a1[k*32 +: 10]];
  end
  always_comb begin
    rd2 = '0;
    for (int k = 0; k < 9; k++) rd2[k*16 +: 16] = mem[a2[k*32 +: 10]];
  end

  function automatic logic [15:0] slot(bit s, int k);
    return s ? w2[k*16 +: 16] : w1[k*16 +: 16];
  endfunction
  function automatic logic [31:0] addr_of(bit s, int k);
    return s ? a2[k*32 +: 32] : a1[k*32 +: 32];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(bit s, logic x);
    if (s) st2 = x; else st1 = x;
  endtask
  task automatic set_rdy(bit s, logic x);
    if (s) rdy2 = x; else rdy1 = x;
  endtask

  // One full scan: model expects windows in row-major order, n = r*OUT_W + c.
  task automatic scan(bit s, int bp_win, bit rnd, int abort_win, int ign_win, bit ident,
                      int exp_done);
    int kk, ww, ss, base, ow, oh, total, n, cyc, hold, r, c;
    bit fin;
    logic rr;
    kk   = s ? 3 : 5;
    ww   = s ? 8 : 28;
    ss   = s ? 2 : 1;
    base = s ? 100 : 0;
    ow   = (ww - kk) / ss + 1;
    oh   = ow;
    total = ow * oh;
    n = 0; cyc = 0; hold = 0; fin = 0;
    @(negedge clk);
    set_start(s, 1'b1);
    set_rdy(s, 1'b1);
    while (!fin && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      set_start(s, 1'b0);
      if (cyc == 1) chk("busy_after_start", s ? b2 : b1, 1);
      if (cyc == 2) chk("first_valid_latency", s ? v2 : v1, 1);
      if (s ? d2 : d1) begin
        fin = 1;
        chk("handshake_count", n, total);
        if (exp_done > 0) chk("done_cycle", cyc, exp_done);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk("idle_after_done", {b2, v2, d2, b1, v1, d1}, 0);
        @(negedge clk);
        chk("start_in_done_ignored", s ? b2 : b1, 0);
      end else if (s ? v2 : v1) begin
        r = n / ow;
        c = n % ow;
        chk("busy_in_scan", s ? b2 : b1, 1);
        chk("win_row", s ? r2 : r1, r);
        chk("win_col", s ? c2 : c1, c);
        chk("win_last", s ? l2 : l1, (n == total - 1));
        chk("addr_hold_slot0", addr_of(s, 0), base + r*ss*ww + c*ss);
        chk("addr_hold_slotN", addr_of(s, kk*kk-1), base + (r*ss+kk-1)*ww + c*ss + kk - 1);
        for (int k = 0; k < kk*kk; k++)
          chk("win_data", slot(s, k), mem[base + (r*ss + k/kk)*ww + c*ss + k%kk]);
        if (ident && !s) begin
          if (n == 0) begin
            chk("w00_slot4", slot(0, 4), 4);
            chk("w00_slot5", slot(0, 5), 28);
            chk("w00_slot24", slot(0, 24), 116);
          end
          if (n == 1) chk("w01_slot24", slot(0, 24), 117);
          if (n == 23) chk("wrap_col", c1, 23);
          if (n == 24) chk("w10_slot0", slot(0, 0), 28);
          if (n == 575) begin
            chk("wlast_slot0", slot(0, 0), 667);
            chk("wlast_slot24", slot(0, 24), 783);
          end
        end
        if (ident && s && n == 5) begin
          chk("s2_w12_addr0", addr_of(1, 0), 120);
          chk("s2_w12_slot0", slot(1, 0), 120);
          chk("s2_w12_slot8", slot(1, 8), 138);
        end
        if (n == ign_win) set_start(s, 1'b1);
        if (n == abort_win) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk("abort_state", {b1, v1, d1, l1}, 0);
          chk("abort_data", w1[15:0], 0);
          @(negedge clk);
          chk("abort_no_done", {b1, d1}, 0);
          return;
        end
        if (n == bp_win && hold < 10) begin
          set_rdy(s, 1'b0);
          hold++;
        end else begin
          rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          set_rdy(s, rr);
          if (rr) n++;
        end
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; st1 = 0; st2 = 0; rdy1 = 0; rdy2 = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
    repeat (2) @(negedge clk);
    chk("rst_outputs1", {b1, d1, v1, l1}, 0);
    chk("rst_rowcol1", {r1, c1}, 0);
    chk("rst_data1", w1[31:0], 0);
    chk("rst_addr1_slot24", a1[24*32 +: 32], 116);
    chk("rst_outputs2", {b2, d2, v2, l2}, 0);
    chk("rst_addr2_slot0", a2[31:0], 100);
    rst_n = 1'b1;
    @(negedge clk);
    scan(0, 2, 0, -1, -1, 1, 1163);
    scan(1, -1, 0, -1, -1, 1, 19);
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    scan(0, -1, 1, 77, 40, 0, 0);
    scan(0, -1, 1, -1, -1, 0, 0);
    scan(1, 4, 1, -1, -1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Read-side sequencer for the multi-port data buffer (1 write port, PORT_NUM combinational read ports).
- Walks a KSIZE x KSIZE window across an IMG_H x IMG_W feature map, stored row-major at BASE_ADDR, and drives all PORT_NUM read addresses for each window position.
- Captures the returned words into a registered window and presents each window to the downstream convolution core through a valid/ready handshake.

Parameters:
- WIDTH, 16, data word width; matches the buffer.
- ADDR_WIDTH, 32, per-port address width; all addresses in the project are 32 bits.
- KSIZE, 5, kernel edge length.
- PORT_NUM, 25, read-port count; must equal KSIZE*KSIZE.
- IMG_W, 28, feature-map width in words; must be >= KSIZE.
- IMG_H, 28, feature-map height in words; must be >= KSIZE.
- STRIDE, 1, window step in both directions; must be >= 1.
- BASE_ADDR, 0, buffer address of map element (0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins a full map scan. Ignored unless the FSM is in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window handshake.
- rd_addr_NP  out  PORT_NUM*ADDR_WIDTH  read addresses to the buffer. Slot k occupies bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH].
- rd_data_NP  in  PORT_NUM*WIDTH  combinational read data from the buffer, same slot order.
- win_data  out  PORT_NUM*WIDTH  registered window; slot k = kernel row k/KSIZE, kernel column k%KSIZE.
- win_valid  out  1  win_data is valid.
- win_ready  in  1  downstream accepts win_data.
- win_row  out  16  output-row index r of the presented window.
- win_col  out  16  output-column index c of the presented window.
- win_last  out  1  presented window is the final window of the map.

Behaviour:
- Derived sizes: OUT_W = (IMG_W-KSIZE)/STRIDE+1 and OUT_H = (IMG_H-KSIZE)/STRIDE+1, both floor division.
- Position counters r and c are registered and 16 bits wide.
- Addressing: slot k = i*KSIZE+j gets address BASE_ADDR + (r*STRIDE+i)*IMG_W + (c*STRIDE+j). Compute at ADDR_WIDTH width, unsigned.
- rd_addr_NP is combinational from r and c only, so it is stable whenever r and c are stable.
- Reset (rst_n low at a clock edge):
  - state=IDLE; r=c=0.
  - win_valid=0, done=0, busy=0, win_last=0, win_row=0, win_col=0, win_data=0.
  - rd_addr_NP therefore shows window (0,0).
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE: if start=1, set r=c=0 and go to FETCH.
- FETCH (exactly 1 cycle):
  - Addresses for (r,c) are on rd_addr_NP.
  - At the closing edge: win_data<=rd_data_NP, win_row<=r, win_col<=c, win_last<=(r==OUT_H-1 && c==OUT_W-1), win_valid<=1. Go to PRESENT.
- PRESENT:
  - Hold win_valid, win_data, win_row, win_col and win_last stable until win_valid&&win_ready.
  - On handshake, set win_valid<=0.
  - If win_last, go to DONE.
  - Else, if c==OUT_W-1: c<=0, r<=r+1; otherwise c<=c+1. Then go to FETCH.
- DONE: done=1 for this single cycle, busy=1, then go to IDLE. r and c are left as-is and are reset on the next start.
- Timing:
  - Latency from start-sample edge to the first win_valid is 2 cycles.
  - Peak throughput is one window per 2 cycles with win_ready held high.
  - win_ready may already be high on the first PRESENT cycle; the handshake completes that cycle.
- start asserted in any non-IDLE state has no effect, including in the DONE cycle.
- rst_n asserted mid-scan: the next edge forces IDLE with all outputs at reset values. The partially delivered scan is abandoned, with no done pulse.
- The buffer contents must not change while busy=1; the writer guarantees this, and the block does no checking.
- Degenerate map: IMG_W==KSIZE and IMG_H==KSIZE gives a single window, with win_last=1 on it.

Test Plan:
- Defaults; preload mem[a]=a for a=0..1023; start; hold win_ready=1 -> first win_valid 2 cycles after start. Window (0,0) slot 0=0, slot 4=4, slot 5=28, slot 24=116, win_last=0.
- Same run, continue -> window (0,1) slot 0=1 and slot 24=117. Window (1,0) has win_row=1, win_col=0, slot 0=28. Column wrap occurs after win_col=23.
- Same run to the end -> exactly 576 handshakes. Last window (23,23): slot 0=667, slot 24=783, win_last=1. done pulses once, on the cycle after that handshake, i.e. 1153 cycles after start; busy then drops.
- Backpressure: hold win_ready=0 for 10 cycles on window (0,2) -> win_valid stays 1, win_data/win_row/win_col are stable, r and c do not advance. Raising win_ready produces exactly one handshake.
- Config KSIZE=3, PORT_NUM=9, IMG_W=IMG_H=8, STRIDE=2, BASE_ADDR=100 -> 9 windows. Window (1,2): slot 0 addr=100+2*8+4=120, slot 8 addr=120+2*8+2=138.
- Reset mid-scan: rst_n low for 1 cycle while window (3,5) is presented -> next cycle win_valid=0, busy=0, no done. A start pulse issued during the scan but before the reset is ignored. A fresh start restarts at window (0,0).
